// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory req/ack channel, datapath redirect/stall inputs,
// and the IR fields presented to the decoder.
interface fetch_unit_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 8
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              inst_valid;
    logic [2:0]        inst1;
    logic              inst2;
    logic [3:0]        operand;
    logic [PC_W-1:0]   ir_pc;
    logic [PC_W-1:0]   pc_plus1;

    modport master (
        output imem_req, imem_addr, inst_valid, inst1, inst2, operand, ir_pc, pc_plus1,
        input  imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst1, inst2, operand, ir_pc, pc_plus1,
        output imem_ack, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, IR valid 1 cycle after an accepted ack.
// Backpressure: req held until ack; stall holds a full IR; redirects during a request are deferred.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [PC_W-1:0]   fetch_pc_q;
    logic [PC_W-1:0]   pending_pc_q;
    logic [PC_W-1:0]   ir_pc_q;
    logic [INST_W-1:0] ir_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= '0;
            ir_pc_q      <= '0;
            ir_q         <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.imem_ack) begin
                        if (bus.redirect) begin
                            fetch_pc_q <= bus.redirect_pc;
                        end else begin
                            ir_q       <= bus.imem_rdata;
                            ir_pc_q    <= fetch_pc_q;
                            fetch_pc_q <= fetch_pc_q + PC_ONE;
                            state_q    <= FULL;
                        end
                    end else if (bus.redirect) begin
                        // Address must stay put until the in-flight request is acked.
                        pending_pc_q <= bus.redirect_pc;
                        state_q      <= DROP;
                    end
                end
                DROP: begin
                    if (bus.redirect) begin
                        pending_pc_q <= bus.redirect_pc;
                    end
                    if (bus.imem_ack) begin
                        fetch_pc_q <= bus.redirect ? bus.redirect_pc : pending_pc_q;
                        state_q    <= FETCH;
                    end
                end
                FULL: begin
                    if (bus.redirect) begin
                        fetch_pc_q <= bus.redirect_pc;
                        state_q    <= FETCH;
                    end else if (!bus.stall) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign bus.imem_req   = (state_q == FETCH) || (state_q == DROP);
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = (state_q == FULL);
    assign bus.inst1      = ir_q[7:5];
    assign bus.inst2      = ir_q[4];
    assign bus.operand    = ir_q[3:0];
    assign bus.ir_pc      = ir_pc_q;
    assign bus.pc_plus1   = ir_pc_q + PC_ONE;
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: memory handshake driven per cycle, accepted fetches scoreboarded.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.PC_W(8), .INST_W(8)) bus();

    fetch_unit #(.PC_W(8), .INST_W(8), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] ir;
        logic [7:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic prev_v      = 1'b0;

    task automatic drive(input logic ack, input logic [7:0] rdata, input logic stl,
                         input logic rdr, input logic [7:0] rpc);
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        bus.stall       = stl;
        bus.redirect    = rdr;
        bus.redirect_pc = rpc;
    endtask

    // Advance one edge; every new instruction appearing in the IR is matched against the scoreboard.
    task automatic step();
        exp_t       e;
        logic [7:0] obs_ir;
        logic [7:0] exp_p1;
        @(posedge clk);
        #1;
        if (bus.inst_valid && !prev_v) begin
            vectors++;
            obs_ir = {bus.inst1, bus.inst2, bus.operand};
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: IR=%h ir_pc=%h appeared, none expected", obs_ir, bus.ir_pc);
            end else begin
                e      = sb_q.pop_front();
                exp_p1 = e.pc + 8'd1;
                if (obs_ir !== e.ir || bus.ir_pc !== e.pc || bus.pc_plus1 !== exp_p1) begin
                    miscompares++;
                    $display("FAIL sb_inst: got IR=%h ir_pc=%h pc_plus1=%h, want IR=%h ir_pc=%h pc_plus1=%h",
                             obs_ir, bus.ir_pc, bus.pc_plus1, e.ir, e.pc, exp_p1);
                end
            end
        end
        prev_v = bus.inst_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step();
        step();
        vectors++; if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", bus.inst_valid); end
        vectors++; if ({bus.inst1, bus.inst2, bus.operand} !== 8'h00) begin miscompares++; $display("FAIL rst_ir: got %h want 00", {bus.inst1, bus.inst2, bus.operand}); end
        vectors++; if (bus.ir_pc !== 8'h00 || bus.pc_plus1 !== 8'h01) begin miscompares++; $display("FAIL rst_pc: got ir_pc=%h pc_plus1=%h want 00/01", bus.ir_pc, bus.pc_plus1); end
        rst_n = 1'b1;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin miscompares++; $display("FAIL rst_req: got req=%b addr=%h want 1/00", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_zero_wait();
        drive(1'b1, 8'h1A, 1'b0, 1'b0, 8'h00);
        sb_q.push_back({8'h1A, 8'h00});
        step();
        vectors++; if (bus.inst_valid !== 1'b1 || bus.inst1 !== 3'b000 || bus.inst2 !== 1'b1 || bus.operand !== 4'hA) begin
            miscompares++; $display("FAIL zw_fields: got v=%b i1=%b i2=%b op=%h want 1/000/1/a", bus.inst_valid, bus.inst1, bus.inst2, bus.operand); end
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL zw_req_full: got %b want 0", bus.imem_req); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step();
        vectors++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 8'h01) begin miscompares++; $display("FAIL zw_next: got v=%b addr=%h want 0/01", bus.inst_valid, bus.imem_addr); end
        drive(1'b1, 8'h3B, 1'b0, 1'b0, 8'h00);
        sb_q.push_back({8'h3B, 8'h01});
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step();
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h02 || bus.inst_valid !== 1'b0) begin
                miscompares++; $display("FAIL ws_hold%0d: got req=%b addr=%h v=%b want 1/02/0", i, bus.imem_req, bus.imem_addr, bus.inst_valid); end
            if (i < 3) step();
        end
        drive(1'b1, 8'h81, 1'b0, 1'b0, 8'h00);
        sb_q.push_back({8'h81, 8'h02});
        step();
        vectors++; if (bus.inst_valid !== 1'b1) begin miscompares++; $display("FAIL ws_valid: got %b want 1", bus.inst_valid); end
    endtask

    task automatic test_stall();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++; if (bus.inst_valid !== 1'b1 || {bus.inst1, bus.inst2, bus.operand} !== 8'h81 || bus.ir_pc !== 8'h02 || bus.imem_req !== 1'b0) begin
                miscompares++; $display("FAIL stall_hold%0d: got v=%b IR=%h ir_pc=%h req=%b want 1/81/02/0",
                                        i, bus.inst_valid, {bus.inst1, bus.inst2, bus.operand}, bus.ir_pc, bus.imem_req); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step();
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h03 || bus.inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL stall_release: got req=%b addr=%h v=%b want 1/03/0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
    endtask

    task automatic test_redirect_full();
        drive(1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
        sb_q.push_back({8'h55, 8'h03});
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h40);
        step();
        vectors++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 8'h40 || bus.imem_req !== 1'b1) begin
            miscompares++; $display("FAIL rdr_full: got v=%b addr=%h req=%b want 0/40/1", bus.inst_valid, bus.imem_addr, bus.imem_req); end
    endtask

    task automatic test_drop();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h20);
        step();
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40) begin miscompares++; $display("FAIL drop_addr1: got req=%b addr=%h want 1/40", bus.imem_req, bus.imem_addr); end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h30);
        step();
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40) begin miscompares++; $display("FAIL drop_addr2: got req=%b addr=%h want 1/40", bus.imem_req, bus.imem_addr); end
        drive(1'b1, 8'hEE, 1'b0, 1'b0, 8'h00);
        step();
        vectors++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 8'h30 || bus.imem_req !== 1'b1) begin
            miscompares++; $display("FAIL drop_ack: got v=%b addr=%h req=%b want 0/30/1", bus.inst_valid, bus.imem_addr, bus.imem_req); end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        step();
        vectors++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 8'h30) begin miscompares++; $display("FAIL drop_stall_ign: got v=%b addr=%h want 0/30", bus.inst_valid, bus.imem_addr); end
        drive(1'b1, 8'h9C, 1'b0, 1'b0, 8'h00);
        sb_q.push_back({8'h9C, 8'h30});
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step();
        vectors++; if (bus.imem_addr !== 8'h31) begin miscompares++; $display("FAIL drop_seq: got addr=%h want 31", bus.imem_addr); end
        drive(1'b1, 8'h77, 1'b0, 1'b1, 8'hFF);
        step();
        vectors++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 8'hFF || bus.imem_req !== 1'b1) begin
            miscompares++; $display("FAIL ackrdr: got v=%b addr=%h req=%b want 0/ff/1", bus.inst_valid, bus.imem_addr, bus.imem_req); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00);
        sb_q.push_back({8'hC3, 8'hFF});
        step();
        vectors++; if (bus.pc_plus1 !== 8'h00) begin miscompares++; $display("FAIL wrap_p1: got %h want 00", bus.pc_plus1); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step();
        vectors++; if (bus.imem_addr !== 8'h00 || bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL wrap_addr: got addr=%h req=%b want 00/1", bus.imem_addr, bus.imem_req); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pc;
        logic [7:0] d;
        pc = 8'h00;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            drive(1'b1, d, 1'b0, 1'b0, 8'h00);
            sb_q.push_back({d, pc});
            step();
            vectors++; if (bus.inst_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid%0d: got %b want 1", i, bus.inst_valid); end
            drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            step();
            pc = pc + 8'd1;
            vectors++; if (bus.imem_addr !== pc) begin miscompares++; $display("FAIL b2b_addr%0d: got %h want %h", i, bus.imem_addr, pc); end
        end
    endtask

    task automatic test_reset_mid_wait();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step();
        vectors++; if (bus.imem_addr !== 8'h06 || bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL rmw_pre: got addr=%h req=%b want 06/1", bus.imem_addr, bus.imem_req); end
        rst_n = 1'b0;
        step();
        vectors++; if (bus.imem_addr !== 8'h00 || bus.inst_valid !== 1'b0 || bus.ir_pc !== 8'h00) begin
            miscompares++; $display("FAIL rmw_rst: got addr=%h v=%b ir_pc=%h want 00/0/00", bus.imem_addr, bus.inst_valid, bus.ir_pc); end
        rst_n = 1'b1;
        drive(1'b1, 8'h5D, 1'b0, 1'b0, 8'h00);
        sb_q.push_back({8'h5D, 8'h00});
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_full();
        test_drop();
        test_wrap();
        test_back_to_back();
        test_reset_mid_wait();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d instructions never delivered, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
